msrv32_rf_wr_arbiter: RTL and testbench

//  Shares the single integer register-file write port between two requesters:
//  - the in-order pipeline writeback, which has priority;
//  - a long-latency unit (LLU: mul/div, slow loads) using a valid/ready handshake.

---
 rtl/msrv32_rf_wr_arbiter_if.sv | 38 +++
 rtl/msrv32_rf_wr_arbiter.sv | 119 +++++++++++
 tb/tb_msrv32_rf_wr_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/msrv32_rf_wr_arbiter_if.sv
// Register-file write arbiter bus. It groups the pipeline writeback request,
// the long-latency-unit handshake, the hazard-visibility signals and the
// register-file write port.
interface msrv32_rf_wr_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              flush_in;
  logic              pipe_wr_en_in;
  logic [ADDR_W-1:0] pipe_rd_addr_in;
  logic [DATA_W-1:0] pipe_rd_data_in;
  logic              llu_valid_in;
  logic [ADDR_W-1:0] llu_rd_addr_in;
  logic [DATA_W-1:0] llu_rd_data_in;
  logic              llu_ready_out;
  logic              pipe_stall_out;
  logic              pend_valid_out;
  logic [ADDR_W-1:0] pend_addr_out;
  logic              wr_en_integer_file_out;
  logic [ADDR_W-1:0] rf_wr_addr_out;
  logic [DATA_W-1:0] rf_wr_data_out;

  // Arbiter side
  modport slave (
    input  flush_in, pipe_wr_en_in, pipe_rd_addr_in, pipe_rd_data_in,
    input  llu_valid_in, llu_rd_addr_in, llu_rd_data_in,
    output llu_ready_out, pipe_stall_out, pend_valid_out, pend_addr_out,
    output wr_en_integer_file_out, rf_wr_addr_out, rf_wr_data_out
  );

  // Requester / register-file side
  modport master (
    output flush_in, pipe_wr_en_in, pipe_rd_addr_in, pipe_rd_data_in,
    output llu_valid_in, llu_rd_addr_in, llu_rd_data_in,
    input  llu_ready_out, pipe_stall_out, pend_valid_out, pend_addr_out,
    input  wr_en_integer_file_out, rf_wr_addr_out, rf_wr_data_out
  );
endinterface

// File: rtl/msrv32_rf_wr_arbiter.sv
// Integer register-file write-port arbiter. Pipeline writeback has priority.
// Long-latency-unit results are parked in a one-entry buffer and written when
// the pipeline leaves the port free. If the pipeline keeps the port busy for
// too long, the arbiter stalls the pipeline for one cycle so the buffer drains.
module msrv32_rf_wr_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   ms_riscv32_mp_clk_in,
  input logic                   ms_riscv32_mp_rst_in,
  msrv32_rf_wr_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic              stall_reg;
  logic              buf_valid_reg;
  logic [ADDR_W-1:0] buf_addr_reg;
  logic [DATA_W-1:0] buf_data_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic pw;      // pipeline write actually taken this cycle
  logic accept;  // LLU handshake completes this cycle
  logic load;    // accepted LLU result needs a register write (rd != x0)
  logic drain;   // buffered LLU result uses the port this cycle

  assign pw     = bus.pipe_wr_en_in & ~bus.flush_in & ~stall_reg &
                  (bus.pipe_rd_addr_in != '0);
  assign accept = bus.llu_valid_in & ~buf_valid_reg;
  assign load   = accept & (bus.llu_rd_addr_in != '0);
  assign drain  = ~pw & buf_valid_reg;

  assign bus.llu_ready_out          = ~buf_valid_reg;
  assign bus.pipe_stall_out         = stall_reg;
  assign bus.pend_valid_out         = buf_valid_reg;
  assign bus.pend_addr_out          = buf_addr_reg;
  assign bus.wr_en_integer_file_out = wr_en_reg;
  assign bus.rf_wr_addr_out         = wr_addr_reg;
  assign bus.rf_wr_data_out         = wr_data_reg;

  // Holding buffer and registered write port; the pipeline wins, and the buffer fills the gaps
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      // Accept only happens with an empty buffer, so it never coincides with a drain
      if (drain) begin
        buf_valid_reg <= 1'b0;
      end else if (load) begin
        buf_valid_reg <= 1'b1;
        buf_addr_reg  <= bus.llu_rd_addr_in;
        buf_data_reg  <= bus.llu_rd_data_in;
      end

      if (pw) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= bus.pipe_rd_addr_in;
        wr_data_reg <= bus.pipe_rd_data_in;
      end else if (buf_valid_reg) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= buf_addr_reg;
        wr_data_reg <= buf_data_reg;
      end else begin
        wr_en_reg   <= 1'b0;
      end
    end
  end

  // Starvation FSM: counts cycles a buffered result is blocked and raises a one-cycle stall
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      stall_reg      <= 1'b0;
    end else begin
      stall_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg      <= WAIT;
            starve_cnt_reg <= '0;
          end
        end
        WAIT: begin
          if (drain) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
          end else begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            if (starve_cnt_reg == CNT_W'(STARVE_LIMIT - 1)) begin
              state_reg <= FORCE;
              stall_reg <= 1'b1;
            end
          end
        end
        FORCE: begin
          // pw is blocked by the stall, so the buffer drains in this cycle
          state_reg      <= IDLE;
          starve_cnt_reg <= '0;
        end
        default: begin
          state_reg      <= IDLE;
          starve_cnt_reg <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_msrv32_rf_wr_arbiter.sv
// Directed bench for the register-file write arbiter.
module tb_msrv32_rf_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  msrv32_rf_wr_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  msrv32_rf_wr_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_in        = 1'b0;
    bus.pipe_wr_en_in   = 1'b0;
    bus.pipe_rd_addr_in = '0;
    bus.pipe_rd_data_in = '0;
    bus.llu_valid_in    = 1'b0;
    bus.llu_rd_addr_in  = '0;
    bus.llu_rd_data_in  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    checks++; if (bus.wr_en_integer_file_out !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en_integer_file_out); end
    checks++; if (bus.rf_wr_addr_out !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.rf_wr_addr_out); end
    checks++; if (bus.rf_wr_data_out !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.rf_wr_data_out); end
    checks++; if (bus.llu_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.llu_ready_out); end
    checks++; if (bus.pipe_stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.pipe_stall_out); end
    checks++; if (bus.pend_valid_out !== 1'b0 || bus.pend_addr_out !== 5'd0) begin failures++; $display("FAIL reset_pend got=%b/%0d exp=0/0", bus.pend_valid_out, bus.pend_addr_out); end
    step();
    rst = 1'b0;
    step();
    $display("tb: test_reset done");
  endtask

  task automatic test_pipe_write();
    bus.pipe_wr_en_in = 1'b1; bus.pipe_rd_addr_in = 5'd5; bus.pipe_rd_data_in = 32'hA5A5A5A5;
    step();
    bus.pipe_wr_en_in = 1'b0;
    checks++; if (bus.wr_en_integer_file_out !== 1'b1 || bus.rf_wr_addr_out !== 5'd5 || bus.rf_wr_data_out !== 32'hA5A5A5A5) begin failures++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/a5a5a5a5", bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.rf_wr_data_out); end
    step();
    checks++; if (bus.wr_en_integer_file_out !== 1'b0 || bus.rf_wr_addr_out !== 5'd5 || bus.rf_wr_data_out !== 32'hA5A5A5A5) begin failures++; $display("FAIL pipe_hold got=%b/%0d/%h exp=0/5/a5a5a5a5", bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.rf_wr_data_out); end
    $display("tb: test_pipe_write done");
  endtask

  task automatic test_llu_write();
    bus.llu_valid_in = 1'b1; bus.llu_rd_addr_in = 5'd7; bus.llu_rd_data_in = 32'h1234;
    checks++; if (bus.llu_ready_out !== 1'b1) begin failures++; $display("FAIL llu_ready_pre got=%b exp=1", bus.llu_ready_out); end
    step();
    bus.llu_valid_in = 1'b0;
    checks++; if (bus.llu_ready_out !== 1'b0 || bus.pend_valid_out !== 1'b1 || bus.pend_addr_out !== 5'd7) begin failures++; $display("FAIL llu_buffered got ready=%b pend=%b/%0d exp 0/1/7", bus.llu_ready_out, bus.pend_valid_out, bus.pend_addr_out); end
    checks++; if (bus.wr_en_integer_file_out !== 1'b0) begin failures++; $display("FAIL llu_early_write got=%b exp=0", bus.wr_en_integer_file_out); end
    step();
    checks++; if (bus.wr_en_integer_file_out !== 1'b1 || bus.rf_wr_addr_out !== 5'd7 || bus.rf_wr_data_out !== 32'h1234) begin failures++; $display("FAIL llu_write got=%b/%0d/%h exp=1/7/1234", bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.rf_wr_data_out); end
    checks++; if (bus.llu_ready_out !== 1'b1 || bus.pend_valid_out !== 1'b0) begin failures++; $display("FAIL llu_release got ready=%b pend=%b exp 1/0", bus.llu_ready_out, bus.pend_valid_out); end
    step();
    $display("tb: test_llu_write done");
  endtask

  task automatic test_starvation();
    int stall_seen = 0;
    bus.pipe_wr_en_in = 1'b1; bus.pipe_rd_addr_in = 5'd1; bus.pipe_rd_data_in = 32'h100;
    bus.llu_valid_in = 1'b1; bus.llu_rd_addr_in = 5'd9; bus.llu_rd_data_in = 32'h99;
    step();
    bus.llu_valid_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic        exp_stall;
      logic        exp_pend;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      exp_stall = (k == 5);
      exp_pend  = (k <= 5);
      exp_addr  = (k == 6) ? 5'd9 : 5'd1;
      exp_data  = (k == 6) ? 32'h99 : 32'h100 + 32'(k - 1);
      if (bus.pipe_stall_out === 1'b1) stall_seen++;
      checks++; if (bus.pipe_stall_out !== exp_stall) begin failures++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, bus.pipe_stall_out, exp_stall); end
      checks++; if (bus.pend_valid_out !== exp_pend) begin failures++; $display("FAIL starve_pend k=%0d got=%b exp=%b", k, bus.pend_valid_out, exp_pend); end
      checks++; if (bus.wr_en_integer_file_out !== 1'b1 || bus.rf_wr_addr_out !== exp_addr || bus.rf_wr_data_out !== exp_data) begin failures++; $display("FAIL starve_port k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.rf_wr_data_out, exp_addr, exp_data); end
      bus.pipe_rd_data_in = 32'h100 + 32'(k);
      step();
    end
    checks++; if (stall_seen != 1) begin failures++; $display("FAIL starve_stall_count got=%0d exp=1", stall_seen); end
    bus.pipe_wr_en_in = 1'b0;
    step();
    $display("tb: test_starvation done");
  endtask

  task automatic test_flush();
    bus.flush_in = 1'b1; bus.pipe_wr_en_in = 1'b1; bus.pipe_rd_addr_in = 5'd3; bus.pipe_rd_data_in = 32'h33;
    step();
    checks++; if (bus.wr_en_integer_file_out !== 1'b0) begin failures++; $display("FAIL flush_gate got=%b exp=0", bus.wr_en_integer_file_out); end
    bus.flush_in = 1'b0; bus.pipe_rd_addr_in = 5'd4; bus.pipe_rd_data_in = 32'h44;
    bus.llu_valid_in = 1'b1; bus.llu_rd_addr_in = 5'd10; bus.llu_rd_data_in = 32'hAA;
    step();
    bus.llu_valid_in = 1'b0;
    bus.flush_in = 1'b1; bus.pipe_rd_addr_in = 5'd3; bus.pipe_rd_data_in = 32'h33;
    checks++; if (bus.wr_en_integer_file_out !== 1'b1 || bus.rf_wr_addr_out !== 5'd4 || bus.pend_valid_out !== 1'b1) begin failures++; $display("FAIL flush_setup got=%b/%0d pend=%b exp=1/4 pend=1", bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.pend_valid_out); end
    step();
    bus.flush_in = 1'b0; bus.pipe_wr_en_in = 1'b0;
    checks++; if (bus.wr_en_integer_file_out !== 1'b1 || bus.rf_wr_addr_out !== 5'd10 || bus.rf_wr_data_out !== 32'hAA) begin failures++; $display("FAIL flush_drain got=%b/%0d/%h exp=1/10/aa", bus.wr_en_integer_file_out, bus.rf_wr_addr_out, bus.rf_wr_data_out); end
    checks++; if (bus.pend_valid_out !== 1'b0) begin failures++; $display("FAIL flush_pend got=%b exp=0", bus.pend_valid_out); end
    step();
    checks++; if (bus.wr_en_integer_file_out !== 1'b0) begin failures++; $display("FAIL flush_idle got=%b exp=0", bus.wr_en_integer_file_out); end
    $display("tb: test_flush done");
  endtask

  task automatic test_rd_zero();
    bus.llu_valid_in = 1'b1; bus.llu_rd_addr_in = 5'd0; bus.llu_rd_data_in = 32'h55;
    bus.pipe_wr_en_in = 1'b1; bus.pipe_rd_addr_in = 5'd0; bus.pipe_rd_data_in = 32'h66;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.wr_en_integer_file_out !== 1'b0 || bus.llu_ready_out !== 1'b1 || bus.pend_valid_out !== 1'b0) begin failures++; $display("FAIL rd_zero k=%0d got wr=%b ready=%b pend=%b exp 0/1/0", k, bus.wr_en_integer_file_out, bus.llu_ready_out, bus.pend_valid_out); end
    end
    idle_inputs();
    step();
    $display("tb: test_rd_zero done");
  endtask

  task automatic test_async_reset();
    bus.pipe_wr_en_in = 1'b1; bus.pipe_rd_addr_in = 5'd2; bus.pipe_rd_data_in = 32'h22;
    bus.llu_valid_in = 1'b1; bus.llu_rd_addr_in = 5'd12; bus.llu_rd_data_in = 32'hCC;
    step();
    idle_inputs();
    checks++; if (bus.pend_valid_out !== 1'b1 || bus.wr_en_integer_file_out !== 1'b1) begin failures++; $display("FAIL areset_setup got pend=%b wr=%b exp 1/1", bus.pend_valid_out, bus.wr_en_integer_file_out); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.wr_en_integer_file_out !== 1'b0 || bus.pend_valid_out !== 1'b0 || bus.llu_ready_out !== 1'b1) begin failures++; $display("FAIL areset_now got wr=%b pend=%b ready=%b exp 0/0/1", bus.wr_en_integer_file_out, bus.pend_valid_out, bus.llu_ready_out); end
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (bus.wr_en_integer_file_out !== 1'b0 || bus.pend_valid_out !== 1'b0) begin failures++; $display("FAIL areset_stale k=%0d got wr=%b pend=%b exp 0/0", k, bus.wr_en_integer_file_out, bus.pend_valid_out); end
    end
    $display("tb: test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_llu_write();
    test_starvation();
    test_flush();
    test_rd_zero();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
